// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: FSM states, opcodes, ALU functions.
// Consumers: ctrl_seq (top) and br_cond (branch decision).
package ctrl_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_FETCH  = FETCH,
        S_DECODE = DECODE,
        S_EXEC   = EXEC,
        S_MEM    = MEM,
        S_HALT   = HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_LOAD  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;
    localparam logic [3:0] OP_JN    = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;

endpackage

// File: rtl/ctrl_seq_br_cond.sv
// Branch decision: JMP always taken, JZ on Z, JN on N, everything else not taken.
module br_cond
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic             z_flag,
    input  logic             n_flag,
    output logic             take
);

    always_comb begin
        take = (opcode == OPC_W'(OP_JMP))
             | ((opcode == OPC_W'(OP_JZ)) & z_flag)
             | ((opcode == OPC_W'(OP_JN)) & n_flag);
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multicycle CPU control sequencer: FETCH -> DECODE -> EXEC/MEM -> FETCH, with HALT.
// Optional feature: define MEM_TIMEOUT_EN to bound memory waits (-> HALT with sticky err).
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             z_flag,
    input  logic             n_flag,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [2:0]       alu_op,
    output logic             flag_we,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             err
);

    state_t r_state;
    logic   w_take;
    logic   w_timeout;
    logic   w_is_load;
    logic   w_is_alu;
    logic   w_is_mem;

    br_cond #(
        .OPC_W (OPC_W)
    ) u_br_cond (
        .opcode (opcode),
        .z_flag (z_flag),
        .n_flag (n_flag),
        .take   (w_take)
    );

    assign w_is_load = (opcode == OPC_W'(OP_LOAD));
    assign w_is_alu  = (opcode == OPC_W'(OP_ADD)) | (opcode == OPC_W'(OP_SUB))
                     | (opcode == OPC_W'(OP_AND));
    assign w_is_mem  = w_is_load | (opcode == OPC_W'(OP_STORE));

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;
    logic             w_waiting;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout = w_waiting && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counter is zero on every entry to FETCH/MEM because it clears whenever no wait is pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_waiting) begin
                if (r_wait_cnt != CNT_W'(TIMEOUT)) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    // Constant 0 in this build; the expression only keeps TIMEOUT referenced.
    assign err       = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (w_timeout) begin
            r_state <= S_HALT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_is_alu) begin
                        r_state <= S_EXEC;
                    end else if (w_is_mem) begin
                        r_state <= S_MEM;
                    end else if (opcode == OPC_W'(OP_HALT)) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        alu_op  = ALU_PASS;
        flag_we = 1'b0;
        reg_we  = 1'b0;
        busy    = (r_state != S_IDLE) && (r_state != S_HALT);
        halted  = (r_state == S_HALT);
        case (r_state)
            S_FETCH: begin
                mem_rd  = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            S_DECODE: begin
                pc_load = w_take;
            end
            S_EXEC: begin
                alu_op  = opcode[2:0];
                reg_we  = 1'b1;
                flag_we = 1'b1;
            end
            S_MEM: begin
                // Anything that is not LOAD is served as a write so MEM can never stall without a request.
                if (w_is_load) begin
                    mem_rd  = 1'b1;
                    alu_op  = ALU_PASS;
                    reg_we  = mem_ready;
                    flag_we = mem_ready;
                end else begin
                    mem_wr  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
